sw_cascade_eval: RTL
====================

Name: sw_cascade_eval

Overview:
- Parametrised successor to the two-stage switch-to-LED cascade.
- N_STAGES configurable 4-input truth-table stages are chained: each stage's output feeds input A of the next stage, and B/C/D come from switches.
- Adds a switch synchroniser and debouncer, optional stage pipelining with operand alignment, a result-valid tracker and a debounced-change counter.
- Sits directly under the board top: switches in, LEDs out.

Parameters:
- N_STAGES, 2, number of cascaded stages (1..8); the switch width is 3*N_STAGES+1.
- STAGE_LUT, {16'h8000,16'hFFFE}, 16*N_STAGES bits of truth tables. Stage k uses bits [16k+15:16k]; default is stage0 = OR4, stage1 = AND4.
- DEBOUNCE_CYCLES, 4, consecutive cycles (>=1) a synchronised bit must differ from its debounced value before it is accepted.
- PIPELINED, 1, 1 = register after every stage; 0 = combinational chain plus one output register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sw  input  3*N_STAGES+1  raw asynchronous switches.
- led  output  N_STAGES  led[k] = registered output of stage k.
- result_valid  output  1  high when led reflects the current debounced switch snapshot.
- change_count  output  8  count of debounced-vector updates, wraps.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset. On reset:
  - synchroniser flops, debounced vector, debounce counters and pipeline registers = 0;
  - led = 0, change_count = 0, result_valid = 0;
  - FSM enters SETTLING with countdown = LAT.
  - A reset mid-operation discards all in-flight state the same way.
- Synchroniser: 2 flops per sw bit; output syn.
- Debounce, per bit:
  - If syn != stb, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and the bits still differ, stb <= syn and the counter clears.
  - If syn == stb, the counter clears, so a glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - stb_upd = 1 for one cycle when any stb bit changes; multiple bits changing in the same cycle give a single stb_upd.
- Stage function: index = {D,C,B,A}; y_k = STAGE_LUT[16k + index].
  - Stage 0: A = stb[0].
  - Stage k>0: A = y_(k-1).
  - B,C,D = stb[3k+1], stb[3k+2], stb[3k+3].
- PIPELINED=1:
  - y_k is registered; led[k] = y_k register.
  - The B/C/D operands of stage k pass through k delay registers so every stage evaluates the same stb snapshot.
  - LAT = N_STAGES.
- PIPELINED=0: the chain is combinational from stb; all led bits are registered together; LAT = 1.
- End-to-end latency: sw change -> stb change = 2 + DEBOUNCE_CYCLES cycles; stb change -> led[N_STAGES-1] = LAT cycles.
- Valid FSM:
  - IDLE: result_valid = 1. On stb_upd -> SETTLING with count = LAT; result_valid drops in the same cycle stb_upd is registered.
  - SETTLING: result_valid = 0; count decrements each cycle. At count == 1 -> IDLE, so result_valid is high LAT cycles after the stb update.
  - stb_upd while in SETTLING reloads count = LAT, so there is no early valid.
- change_count: +1 per stb_upd cycle; 255 -> 0 wraps silently.
- Unused or illegal parameter values are not supported; N_STAGES is outside 1..8 only by designer error, and no run-time check is made.

Test Plan:
- Reset release, N=2, defaults, sw=0:
  - -> led = 2'b00, change_count = 0;
  - result_valid = 0 for 2 cycles after reset deasserts, then 1.
- Clean step: sw goes 0 -> 7'b1110001 (sw[0]=1, sw[4..6]=1) and is held:
  - -> stb updates 6 cycles after the change;
  - led[0] = 1 one cycle later, led[1] = 1 two cycles later;
  - result_valid low during those 2 cycles, then high;
  - change_count = 1.
- Glitch: sw[3] pulses high for 3 cycles with DEBOUNCE_CYCLES = 4 -> no stb change, led unchanged, change_count unchanged, result_valid stays 1.
- Back-to-back: a second switch change is accepted 1 cycle after the first stb update -> the SETTLING count reloads, result_valid stays low until 2 cycles after the second update, and change_count increments by 2.
- PIPELINED=0, N=3, LUT = XOR4 for all stages, sw = 10'b0000000001:
  - -> led = 3'b111 exactly 1 cycle after the stb update;
  - result_valid high in the next cycle.
- Wrap and reset mid-operation:
  - Toggle sw[0] 256 times with full debounce each time -> change_count reads 0 after the 256th update.
  - Assert reset during SETTLING -> next cycle led = 0, change_count = 0, result_valid = 0.

Source files
------------

// File: rtl/sw_cascade_eval.sv
// sw_cascade_eval
//   Switch-to-LED cascade evaluator. Raw switches are synchronised and
//   debounced. The resulting stable snapshot then drives N_STAGES chained
//   4-input truth-table stages. Each stage's output feeds input A of the next
//   stage, and the B/C/D inputs come from switches. A small FSM reports when
//   the LEDs reflect the current snapshot. A wrapping 8-bit counter tallies
//   snapshot updates.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   sw            raw asynchronous switches, 3*N_STAGES+1 bits
//   led           led[k] = registered output of stage k
//   result_valid  high when led reflects the current debounced snapshot
//   change_count  number of debounced-vector updates, wraps at 256
module sw_cascade_eval #(
    parameter int                       N_STAGES        = 2,
    parameter logic [16*N_STAGES-1:0]   STAGE_LUT       = {16'h8000, 16'hFFFE},
    parameter int                       DEBOUNCE_CYCLES = 4,
    parameter int                       PIPELINED       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*N_STAGES:0]     sw,
    output logic [N_STAGES-1:0]     led,
    output logic                    result_valid,
    output logic [7:0]              change_count
);

    localparam int SW_W  = 3 * N_STAGES + 1;
    localparam int LAT   = (PIPELINED != 0) ? N_STAGES : 1;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       LAT_CNT = 4'(LAT);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    // Truth-table lookup: index is {D,C,B,A}.
    function automatic logic lut_bit(input logic [15:0] tbl, input logic [3:0] idx);
        return tbl[idx];
    endfunction

    logic [SW_W-1:0]    sync1_r;
    logic [SW_W-1:0]    syn_r;
    logic [SW_W-1:0]    stb_r;
    logic [SW_W-1:0]    accept_s;
    logic [CNT_W-1:0]   db_cnt_r [SW_W];
    logic               stb_upd_s;
    state_t             state_r;
    state_t             state_s;
    logic [3:0]         count_r;
    logic [3:0]         count_s;
    logic               valid_r;
    logic [7:0]         change_count_r;

    // Two-flop synchroniser for every switch bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= '0;
            syn_r   <= '0;
        end else begin
            sync1_r <= sw;
            syn_r   <= sync1_r;
        end
    end

    // A bit is accepted on its DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < SW_W; i++) begin
            accept_s[i] = (syn_r[i] != stb_r[i]) && (db_cnt_r[i] == DB_LAST);
        end
    end

    // All bits accepted in the same cycle count as a single update.
    assign stb_upd_s = |accept_s;

    // Per-bit debounce counters and the stable (debounced) vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_r <= '0;
            for (int i = 0; i < SW_W; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SW_W; i++) begin
                if (syn_r[i] == stb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (accept_s[i]) begin
                    db_cnt_r[i] <= '0;
                    stb_r[i]    <= syn_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    generate
        if (PIPELINED != 0) begin : g_pipe
            logic [N_STAGES-1:0] y_vec_s;

            for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
                logic [2:0] bcd_s;
                logic       a_s;
                logic       y_r;

                if (k == 0) begin : g_head
                    assign bcd_s = stb_r[3:1];
                    assign a_s   = stb_r[0];
                end else begin : g_tail
                    // B/C/D of stage k lag k cycles so they meet y_(k-1) of the same snapshot.
                    logic [2:0] dly_r [k];

                    // Operand alignment delay line.
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            for (int j = 0; j < k; j++) begin
                                dly_r[j] <= 3'b000;
                            end
                        end else begin
                            dly_r[0] <= stb_r[3*k+1 +: 3];
                            for (int j = 1; j < k; j++) begin
                                dly_r[j] <= dly_r[j-1];
                            end
                        end
                    end

                    assign bcd_s = dly_r[k-1];
                    assign a_s   = y_vec_s[k-1];
                end

                // Stage output register.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        y_r <= 1'b0;
                    end else begin
                        y_r <= lut_bit(STAGE_LUT[16*k +: 16], {bcd_s, a_s});
                    end
                end

                assign y_vec_s[k] = y_r;
            end

            assign led = y_vec_s;
        end else begin : g_comb
            logic [N_STAGES-1:0] chain_s;
            logic [N_STAGES-1:0] led_r;

            // Whole cascade evaluated combinationally from the stable vector.
            always_comb begin
                logic a_v;
                logic y_v;
                chain_s = '0;
                a_v     = stb_r[0];
                y_v     = 1'b0;
                for (int k = 0; k < N_STAGES; k++) begin
                    y_v        = lut_bit(STAGE_LUT[16*k +: 16], {stb_r[3*k+1 +: 3], a_v});
                    chain_s[k] = y_v;
                    a_v        = y_v;
                end
            end

            // Single output register for all stages.
            always_ff @(posedge clk) begin
                if (reset) begin
                    led_r <= '0;
                end else begin
                    led_r <= chain_s;
                end
            end

            assign led = led_r;
        end
    endgenerate

    // Valid tracker next state. Any update (re)loads the LAT-cycle settle window.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (stb_upd_s) begin
                    state_s = ST_SETTLING;
                    count_s = LAT_CNT;
                end else begin
                    count_s = count_r;
                end
            end
            ST_SETTLING: begin
                if (stb_upd_s) begin
                    count_s = LAT_CNT;
                end else if (count_r == 4'd1) begin
                    state_s = ST_IDLE;
                    count_s = 4'd0;
                end else begin
                    count_s = count_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_SETTLING;
                count_s = LAT_CNT;
            end
        endcase
    end

    // Valid tracker state, registered valid flag and update counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_SETTLING;
            count_r        <= LAT_CNT;
            valid_r        <= 1'b0;
            change_count_r <= 8'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            valid_r <= (state_s == ST_IDLE);
            if (stb_upd_s) begin
                change_count_r <= change_count_r + 8'd1;
            end else begin
                change_count_r <= change_count_r;
            end
        end
    end

    assign result_valid = valid_r;
    assign change_count = change_count_r;

endmodule
